// File: rtl/sbox_sched.sv
// Shares one registered S-box among NUM_BOX chunks: it issues the chunks one per cycle, then collects the results into out_data.
// Optional SBOX_SCHED_COUNT_EN adds a 16-bit done_count of result handshakes.
module sbox_sched #(
    parameter int DATA_WIDTH = 6,
    parameter int OUT_WIDTH  = 4,
    parameter int NUM_BOX    = 8,
    localparam int SEL_W     = (NUM_BOX > 1) ? $clog2(NUM_BOX) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_BOX*DATA_WIDTH-1:0] in_data,
    output logic [SEL_W-1:0]              sbox_sel,
    output logic [DATA_WIDTH-1:0]         sbox_in,
    output logic                          sbox_en,
    input  logic [OUT_WIDTH-1:0]          sbox_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_BOX*OUT_WIDTH-1:0]  out_data
`ifdef SBOX_SCHED_COUNT_EN
    ,
    output logic [15:0]                   done_count
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_BOX - 1);

    state_t                        state_q, state_d;
    logic [SEL_W-1:0]              idx;
    logic                          cap_flag;
    logic [SEL_W-1:0]              cap_idx;
    logic [NUM_BOX*DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0]         chunks [NUM_BOX];
    logic                          accept;
    logic                          handshake;

    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid & in_ready & ~flush;
    assign handshake = out_valid & out_ready;

    // Chunk 0 sits in the most significant bits of the latched block.
    always_comb begin
        for (int i = 0; i < NUM_BOX; i++) begin
            chunks[i] = data_q[(NUM_BOX-1-i)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        sbox_en  = 1'b0;
        sbox_sel = '0;
        sbox_in  = '0;
        case (state_q)
            IDLE:  if (accept) state_d = ISSUE;
            ISSUE: begin
                sbox_en  = 1'b1;
                sbox_sel = idx;
                sbox_in  = chunks[idx];
                if (idx == LAST_IDX) state_d = WAIT;
            end
            WAIT:  state_d = DONE;
            DONE:  if (handshake) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            cap_flag  <= 1'b0;
            cap_idx   <= '0;
            data_q    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            idx       <= '0;
            cap_flag  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // The S-box output is registered, so the strobe is delayed one cycle to match it.
            cap_flag <= sbox_en;
            cap_idx  <= sbox_sel;

            if (accept) begin
                data_q   <= in_data;
                out_data <= '0;
                idx      <= '0;
            end else if (state_q == ISSUE) begin
                idx <= idx + SEL_W'(1);
            end

            if (cap_flag) begin
                for (int i = 0; i < NUM_BOX; i++) begin
                    if (cap_idx == SEL_W'(i)) begin
                        out_data[(NUM_BOX-1-i)*OUT_WIDTH +: OUT_WIDTH] <= sbox_out;
                    end
                end
            end

            if (state_q == WAIT)  out_valid <= 1'b1;
            else if (handshake)   out_valid <= 1'b0;
        end
    end

`ifdef SBOX_SCHED_COUNT_EN
    // Counts every delivered result; a flush does not touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            done_count <= 16'd0;
        else if (handshake) done_count <= done_count + 16'd1;
    end
`endif

endmodule
